// File: rtl/lsu_bus_master.sv
// lsu_bus_master: bridges RV32I load/store requests to a single-beat request/response data bus.
// Parameter TIMEOUT_CYCLES: WAIT cycles without d_valid_i before the access is aborted with lsu_err_o.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are trapped in IDLE instead of issued aligned.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   lsu_req_i/we_i/funct3_i/addr_i/wdata_i   core request (held until lsu_done_o)
//   lsu_stall_o, lsu_done_o, lsu_rdata_o, lsu_err_o, lsu_misalign_o   core status/result
//   a_valid_o/address_o/opcode_o/data_o/size_o/mask_o                 bus request channel
//   d_valid_i/opcode_i/data_i                                          bus response channel
module lsu_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_stall_o,
    output logic        lsu_done_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        lsu_misalign_o,
    output logic        a_valid_o,
    output logic [11:0] a_address_o,
    output logic [2:0]  a_opcode_o,
    output logic [31:0] a_data_o,
    output logic [1:0]  a_size_o,
    output logic [3:0]  a_mask_o,
    input  logic        d_valid_i,
    input  logic [2:0]  d_opcode_i,
    input  logic [31:0] d_data_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic        we_q, we_d, err_q, err_d, mis_q, mis_d;
    logic [2:0]  f3_q, f3_d;
    logic [13:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        misaligned, is_req, is_resp;
    logic [1:0]  size;
    logic [3:0]  mask;
    logic [31:0] wrepl, load_val;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        unused_bits;
    assign unused_bits = ^{d_opcode_i, lsu_addr_i[31:14]};
`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = lsu_funct3_i[1] ? (lsu_addr_i[1:0] != 2'b00) : (lsu_funct3_i[0] & lsu_addr_i[0]);
`else
    assign misaligned = 1'b0;
`endif
    // funct3[1:0] selects width; funct3[2] set means zero-extend on loads
    assign size      = f3_q[1] ? 2'b10 : {1'b0, f3_q[0]};
    assign mask      = f3_q[1] ? 4'hF : f3_q[0] ? (addr_q[1] ? 4'hC : 4'h3) : 4'b0001 << addr_q[1:0];
    assign wrepl     = f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    assign byte_lane = d_data_i[8*addr_q[1:0] +: 8];
    assign half_lane = addr_q[1] ? d_data_i[31:16] : d_data_i[15:0];
    assign load_val  = f3_q[1] ? d_data_i
                     : f3_q[0] ? {{16{~f3_q[2] & half_lane[15]}}, half_lane}
                     : {{24{~f3_q[2] & byte_lane[7]}}, byte_lane};
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: if (lsu_req_i) begin
                we_d    = lsu_we_i;
                f3_d    = lsu_funct3_i;
                addr_d  = lsu_addr_i[13:0];
                wdata_d = lsu_wdata_i;
                rdata_d = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
                mis_d   = misaligned;
                state_d = misaligned ? RESP : REQ;
            end
            REQ:  state_d = WAIT;
            WAIT: if (d_valid_i) begin
                state_d = RESP;
                rdata_d = we_q ? '0 : load_val;
            end else if (cnt_q == 5'(TIMEOUT_CYCLES - 1)) begin
                // this is the TIMEOUT_CYCLES-th WAIT cycle without a response
                state_d = RESP;
                err_d   = 1'b1;
                rdata_d = '0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end
    assign is_req         = state_q == REQ;
    assign is_resp        = state_q == RESP;
    assign a_valid_o      = is_req;
    assign a_address_o    = is_req ? addr_q[13:2] : '0;
    assign a_opcode_o     = (is_req & ~we_q) ? 3'b100 : 3'b000;
    assign a_size_o       = is_req ? size : '0;
    assign a_mask_o       = is_req ? mask : '0;
    assign a_data_o       = is_req ? wrepl : '0;
    // rst_n gates the IDLE term so stall is low throughout reset even if the core requests
    assign lsu_stall_o    = rst_n & (((state_q == IDLE) & lsu_req_i) | is_req | (state_q == WAIT));
    assign lsu_done_o     = is_resp;
    assign lsu_rdata_o    = is_resp ? rdata_q : '0;
    assign lsu_err_o      = is_resp & err_q;
    assign lsu_misalign_o = is_resp & mis_q;
endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: directed self-checking bench for lsu_bus_master.
module tb_lsu_bus_master;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0;
    logic [2:0]  lsu_funct3_i = '0;
    logic [31:0] lsu_addr_i = '0, lsu_wdata_i = '0;
    logic        lsu_stall_o, lsu_done_o, lsu_err_o, lsu_misalign_o;
    logic [31:0] lsu_rdata_o;
    logic        a_valid_o;
    logic [11:0] a_address_o;
    logic [2:0]  a_opcode_o;
    logic [31:0] a_data_o;
    logic [1:0]  a_size_o;
    logic [3:0]  a_mask_o;
    logic        d_valid_i = 1'b0;
    logic [2:0]  d_opcode_i = '0;
    logic [31:0] d_data_i = '0;
    int tests = 0, fails = 0;
    lsu_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_funct3_i(lsu_funct3_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o),
        .lsu_err_o(lsu_err_o), .lsu_misalign_o(lsu_misalign_o),
        .a_valid_o(a_valid_o), .a_address_o(a_address_o), .a_opcode_o(a_opcode_o),
        .a_data_o(a_data_o), .a_size_o(a_size_o), .a_mask_o(a_mask_o),
        .d_valid_i(d_valid_i), .d_opcode_i(d_opcode_i), .d_data_i(d_data_i)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // called at a negedge in IDLE; returns at the negedge of the REQ cycle
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_funct3_i = f3; lsu_addr_i = addr; lsu_wdata_i = wd;
        #1 chk("idle_stall", lsu_stall_o, 1);
        @(negedge clk);
    endtask
    // from the REQ negedge: wait extra cycles, respond, return at the RESP negedge
    task automatic respond(input int delay, input logic [31:0] data, input logic keep);
        @(negedge clk);
        repeat (delay) @(negedge clk);
        d_valid_i = 1'b1; d_data_i = data; d_opcode_i = 3'b001;
        @(negedge clk);
        d_valid_i = 1'b0;
        lsu_req_i = keep;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int n;
        lsu_req_i = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_a_valid", a_valid_o, 0);
        chk("rst_stall", lsu_stall_o, 0);
        chk("rst_done", lsu_done_o, 0);
        chk("rst_opcode", a_opcode_o, 0);
        lsu_req_i = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        issue(0, 3'b010, 32'h0000_0008, 0);
        chk("lw_a_valid", a_valid_o, 1);
        chk("lw_addr", a_address_o, 12'h002);
        chk("lw_mask", a_mask_o, 4'hF);
        chk("lw_opcode", a_opcode_o, 3'b100);
        chk("lw_size", a_size_o, 2'b10);
        respond(0, 32'hDEAD_BEEF, 1);
        chk("lw_done", lsu_done_o, 1);
        chk("lw_rdata", lsu_rdata_o, 32'hDEAD_BEEF);
        chk("lw_err", lsu_err_o, 0);
        chk("lw_resp_stall", lsu_stall_o, 0);
        @(negedge clk);
        chk("b2b_idle_done", lsu_done_o, 0);
        chk("b2b_idle_rdata", lsu_rdata_o, 0);
        chk("b2b_idle_stall", lsu_stall_o, 1);
        chk("b2b_idle_valid", a_valid_o, 0);
        @(negedge clk);
        chk("b2b_req_valid", a_valid_o, 1);
        respond(2, 32'h1234_5678, 0);
        chk("b2b_wait_done", lsu_done_o, 1);
        chk("b2b_rdata", lsu_rdata_o, 32'h1234_5678);
        @(negedge clk);
        issue(0, 3'b000, 32'h0000_0003, 0);
        chk("lb_mask", a_mask_o, 4'h8);
        chk("lb_size", a_size_o, 2'b00);
        respond(0, 32'h8000_0000, 0);
        chk("lb_rdata", lsu_rdata_o, 32'hFFFF_FF80);
        @(negedge clk);
        issue(0, 3'b100, 32'h0000_0003, 0);
        respond(0, 32'h8000_0000, 0);
        chk("lbu_rdata", lsu_rdata_o, 32'h0000_0080);
        @(negedge clk);
        issue(1, 3'b001, 32'h0000_0002, 32'h0000_1234);
        chk("sh_opcode", a_opcode_o, 3'b000);
        chk("sh_size", a_size_o, 2'b01);
        chk("sh_mask", a_mask_o, 4'hC);
        chk("sh_data", a_data_o, 32'h1234_1234);
        chk("sh_addr", a_address_o, 12'h000);
        respond(1, 32'hFFFF_FFFF, 0);
        chk("sh_done", lsu_done_o, 1);
        chk("sh_rdata", lsu_rdata_o, 0);
        @(negedge clk);
        issue(1, 3'b000, 32'h0000_1001, 32'h0000_00AB);
        chk("sb_addr", a_address_o, 12'h400);
        chk("sb_mask", a_mask_o, 4'h2);
        chk("sb_data", a_data_o, 32'hABAB_ABAB);
        respond(0, 0, 0);
        chk("sb_done", lsu_done_o, 1);
        @(negedge clk);
        issue(0, 3'b001, 32'h0000_0002, 0);
        chk("lh_mask", a_mask_o, 4'hC);
        respond(0, 32'h8001_7FFF, 0);
        chk("lh_rdata", lsu_rdata_o, 32'hFFFF_8001);
        @(negedge clk);
        issue(0, 3'b101, 32'h0000_0000, 0);
        chk("lhu_mask", a_mask_o, 4'h3);
        respond(0, 32'h8001_7FFF, 0);
        chk("lhu_rdata", lsu_rdata_o, 32'h0000_7FFF);
        @(negedge clk);
        d_valid_i = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("idle_dvalid_done", lsu_done_o, 0);
        chk("idle_dvalid_stall", lsu_stall_o, 0);
        d_valid_i = 1'b0;
        issue(0, 3'b010, 32'h0000_0010, 0);
        @(negedge clk);
        n = 1;
        chk("wait_stall", lsu_stall_o, 1);
        while (!lsu_done_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycle", n, 17);
        chk("timeout_err", lsu_err_o, 1);
        chk("timeout_rdata", lsu_rdata_o, 0);
        chk("timeout_stall", lsu_stall_o, 0);
        lsu_req_i = 1'b0;
        @(negedge clk);
        chk("timeout_after_err", lsu_err_o, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_funct3_i = 3'b010; lsu_addr_i = 32'h0000_0021;
        @(negedge clk);
        chk("mis_a_valid", a_valid_o, 0);
        chk("mis_done", lsu_done_o, 1);
        chk("mis_flag", lsu_misalign_o, 1);
        chk("mis_rdata", lsu_rdata_o, 0);
        lsu_req_i = 1'b0;
`else
        issue(0, 3'b010, 32'h0000_0021, 0);
        chk("mis_addr", a_address_o, 12'h008);
        chk("mis_mask", a_mask_o, 4'hF);
        respond(0, 32'hCAFE_F00D, 0);
        chk("mis_rdata", lsu_rdata_o, 32'hCAFE_F00D);
        chk("mis_flag", lsu_misalign_o, 0);
`endif
        @(negedge clk);
        issue(0, 3'b010, 32'h0000_0008, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_stall", lsu_stall_o, 0);
        chk("rst_wait_valid", a_valid_o, 0);
        chk("rst_wait_done", lsu_done_o, 0);
        @(negedge clk);
        lsu_req_i = 1'b0; rst_n = 1'b1; d_valid_i = 1'b1; d_data_i = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("post_rst_done1", lsu_done_o, 0);
        @(negedge clk);
        chk("post_rst_done2", lsu_done_o, 0);
        chk("post_rst_rdata", lsu_rdata_o, 0);
        chk("post_rst_stall", lsu_stall_o, 0);
        d_valid_i = 1'b0;
        issue(0, 3'b000, 32'h0000_0001, 0);
        chk("post_rst_req", a_valid_o, 1);
        chk("post_rst_mask", a_mask_o, 4'h2);
        respond(0, 32'h0000_7F00, 0);
        chk("post_rst_rdata_lb", lsu_rdata_o, 32'h0000_007F);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
